// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Brief   : Shared types and defaults for the run/stop even clock divider.
// Revision: 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_CW       = 8;
    localparam int DIV_DEF_HALF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_half_cnt.sv
`default_nettype none
// ============================================================================
// Module  : div_half_cnt
// Brief   : Half-period up-counter; flags the last cycle of a clk_out phase.
// Revision: 1.0 - initial release
// ============================================================================
module div_half_cnt
    import div_pkg::*;
#(
    parameter int CW = DIV_CW
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          clr,
    input  logic          run,
    input  logic [CW-1:0] half,
    output logic          hit
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // half is never zero, so the count stays within 0..half-1
    assign hit = run && (cnt_q == (half - CW'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || hit) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : div_ctrl
// Brief   : Glitch-free run/stop and ratio controller for an even divider.
// Revision: 1.0 - initial release
// ============================================================================
module div_ctrl
    import div_pkg::*;
#(
    parameter int CW       = DIV_CW,
    parameter int DEF_HALF = DIV_DEF_HALF
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          en,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_half,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic          clk_out,
    output logic          rise_tick,
    output logic          busy,
    output logic [CW-1:0] cur_half
);

    div_state_e    state_q, state_d;
    logic          clk_q, clk_d;
    logic          rise_q, rise_d;
    logic          err_q, err_d;
    logic          pend_v_q, pend_v_d;
    logic [CW-1:0] pend_q, pend_d;
    logic [CW-1:0] half_q, half_d;
    logic          w_hit;
    logic          w_apply;
    logic          w_accept;
    logic          w_cnt_clr;
    logic          w_cnt_run;

    assign w_cnt_clr = (state_q == ST_IDLE);
    assign w_cnt_run = (state_q != ST_IDLE);

    div_half_cnt #(
        .CW (CW)
    ) u_half_cnt (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (w_cnt_clr),
        .run    (w_cnt_run),
        .half   (half_q),
        .hit    (w_hit)
    );

    always_comb begin
        state_d = state_q;
        clk_d   = clk_q;
        rise_d  = 1'b0;
        w_apply = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clk_d   = 1'b0;
                w_apply = pend_v_q;
                if (en) begin
                    state_d = ST_RUN;
                    clk_d   = 1'b1;
                    rise_d  = 1'b1;
                end
            end
            ST_RUN, ST_STOP: begin
                if (!en) begin
                    // Stopping only ever ends on a toggle point, and never with a rise
                    if (state_q == ST_RUN) begin
                        state_d = ST_STOP;
                    end else if (w_hit) begin
                        state_d = ST_IDLE;
                        clk_d   = 1'b0;
                    end
                end else begin
                    state_d = ST_RUN;
                    if (w_hit) begin
                        clk_d   = !clk_q;
                        rise_d  = !clk_q;
                        w_apply = !clk_q && pend_v_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                clk_d   = 1'b0;
            end
        endcase
    end

    // A pending value blocks new offers, so accept and apply never coincide
    assign w_accept = cfg_valid && !pend_v_q;

    always_comb begin
        half_d   = w_apply ? pend_q : half_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q && !w_apply;
        err_d    = 1'b0;
        if (w_accept) begin
            if (cfg_half == '0) begin
                err_d = 1'b1;
            end else begin
                pend_d   = cfg_half;
                pend_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            clk_q    <= 1'b0;
            rise_q   <= 1'b0;
            err_q    <= 1'b0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            half_q   <= CW'(DEF_HALF);
        end else begin
            state_q  <= state_d;
            clk_q    <= clk_d;
            rise_q   <= rise_d;
            err_q    <= err_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            half_q   <= half_d;
        end
    end

    assign cfg_ready = !pend_v_q;
    assign cfg_err   = err_q;
    assign clk_out   = clk_q;
    assign rise_tick = rise_q;
    assign busy      = (state_q != ST_IDLE);
    assign cur_half  = half_q;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_ctrl
// Brief   : Self-checking bench for div_ctrl against a phase-remaining model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    localparam int DEF = 4;

    logic       clk_in    = 1'b0;
    logic       reset     = 1'b0;
    logic       en        = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_half  = 8'd0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       rise_tick;
    logic       busy;
    logic [7:0] cur_half;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    div_ctrl dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .busy      (busy),
        .cur_half  (cur_half)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks cycles remaining in the current phase rather than a count-up
    bit m_busy, m_stop, m_lvl, m_tick, m_err, m_acc;
    int m_rem, m_half;
    int m_pend[$];

    always @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_stop = 0; m_lvl = 0; m_tick = 0; m_err = 0;
            m_rem  = 0; m_half = DEF;
            m_pend.delete();
        end else begin
            m_acc  = cfg_valid && (m_pend.size() == 0);
            m_tick = 0;
            m_err  = 0;
            if (!m_busy) begin
                if (m_pend.size() > 0) m_half = m_pend.pop_front();
                if (en) begin
                    m_busy = 1; m_stop = 0; m_lvl = 1; m_tick = 1; m_rem = m_half;
                end
            end else if (!en && !m_stop) begin
                m_stop = 1;
                m_rem  = (m_rem == 1) ? m_half : m_rem - 1;
            end else if (!en) begin
                if (m_rem == 1) begin
                    m_lvl = 0; m_busy = 0; m_stop = 0;
                end else begin
                    m_rem--;
                end
            end else begin
                m_stop = 0;
                if (m_rem == 1) begin
                    m_lvl = !m_lvl;
                    if (m_lvl) begin
                        m_tick = 1;
                        if (m_pend.size() > 0) m_half = m_pend.pop_front();
                    end
                    m_rem = m_half;
                end else begin
                    m_rem--;
                end
            end
            if (m_acc) begin
                if (cfg_half == 8'd0) m_err = 1;
                else m_pend.push_back(int'(cfg_half));
            end
        end
    end

    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("m_clk_out",   clk_out,   m_lvl);
            check("m_rise_tick", rise_tick, m_tick);
            check("m_cfg_err",   cfg_err,   m_err);
            check("m_busy",      busy,      m_busy);
            check("m_cfg_ready", cfg_ready, m_pend.size() == 0);
            check("m_cur_half",  cur_half,  m_half);
        end
    end

    task automatic wait_tick(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (rise_tick !== 1'b1 && n < budget);
        check(name, rise_tick, 1'b1);
    endtask

    task automatic wait_ready(input logic val, input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (cfg_ready !== val && n < budget);
        check(name, cfg_ready, val);
    endtask

    initial begin
        logic [15:0] pat;
        logic [15:0] tpat;
        logic [15:0] rpat;

        repeat (2) @(negedge clk_in);
        check("rst_clk_out",   clk_out,   1'b0);
        check("rst_rise_tick", rise_tick, 1'b0);
        check("rst_cfg_err",   cfg_err,   1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_cur_half",  cur_half,  8'd4);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Default start: 4 high / 4 low, tick on each rise
        @(negedge clk_in);
        en = 1'b1;
        @(negedge clk_in);
        pat = '0; tpat = '0;
        for (int i = 0; i < 16; i++) begin
            pat  = {pat[14:0],  clk_out};
            tpat = {tpat[14:0], rise_tick};
            @(negedge clk_in);
        end
        check("start_pattern", pat,  16'hF0F0);
        check("start_ticks",   tpat, 16'h8080);

        // Ratio change offered in the high phase
        wait_tick(20, "wait_rise_ratio");
        cfg_valid = 1'b1; cfg_half = 8'd2;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        pat = '0; rpat = '0;
        for (int i = 0; i < 12; i++) begin
            pat  = {pat[14:0],  clk_out};
            rpat = {rpat[14:0], cfg_ready};
            @(negedge clk_in);
        end
        check("ratio_pattern", pat[11:0],  12'hE19);
        check("ratio_ready",   rpat[11:0], 12'h01F);
        check("ratio_half",    cur_half,   8'd2);

        // Zero half-period rejected
        cfg_valid = 1'b1; cfg_half = 8'd0;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        check("zero_err",   cfg_err,   1'b1);
        check("zero_ready", cfg_ready, 1'b1);
        check("zero_half",  cur_half,  8'd2);
        @(negedge clk_in);
        check("zero_err_clr", cfg_err, 1'b0);

        // Switch to half=3, then stop one cycle into the high phase
        @(negedge clk_in);
        cfg_valid = 1'b1; cfg_half = 8'd3;
        wait_ready(1'b0, 10, "half3_accept");
        cfg_valid = 1'b0;
        wait_ready(1'b1, 20, "half3_apply");
        check("half3_tick", rise_tick, 1'b1);
        check("half3_half", cur_half,  8'd3);
        en = 1'b0;
        pat = '0; rpat = '0;
        for (int i = 0; i < 6; i++) begin
            pat  = {pat[14:0],  clk_out};
            rpat = {rpat[14:0], busy};
            @(negedge clk_in);
        end
        check("stop_pattern", pat[5:0],  6'h38);
        check("stop_busy",    rpat[5:0], 6'h38);

        // Stop cancelled inside STOP leaves the waveform undisturbed
        en = 1'b1;
        @(negedge clk_in);
        check("restart_tick", rise_tick, 1'b1);
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            pat = {pat[14:0], clk_out};
            if (i == 0) en = 1'b0;
            if (i == 1) en = 1'b1;
            @(negedge clk_in);
        end
        check("cancel_pattern", pat[11:0], 12'hE38);

        // Back-to-back config: second offer held off until the first applies
        cfg_valid = 1'b1; cfg_half = 8'd5;
        @(negedge clk_in);
        check("b2b_blocked", cfg_ready, 1'b0);
        cfg_half = 8'd6;
        wait_ready(1'b1, 30, "b2b_apply5");
        check("b2b_tick5", rise_tick, 1'b1);
        check("b2b_half5", cur_half,  8'd5);
        @(negedge clk_in);
        cfg_valid = 1'b0;
        repeat (9) @(negedge clk_in);
        check("b2b_tick6", rise_tick, 1'b1);
        check("b2b_half6", cur_half,  8'd6);

        // Asynchronous reset in the middle of a high phase
        wait_tick(20, "wait_rise_reset");
        #2;
        reset = 1'b0;
        #1;
        check("areset_clk_out", clk_out,   1'b0);
        check("areset_busy",    busy,      1'b0);
        check("areset_half",    cur_half,  8'd4);
        check("areset_ready",   cfg_ready, 1'b1);
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        check("post_reset_tick", rise_tick, 1'b1);
        check("post_reset_half", cur_half,  8'd4);
        en = 1'b0;
        repeat (12) @(negedge clk_in);
        check("final_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
